// File: rtl/sdp_ram_be_clr_pkg.sv
// Shared constants and FSM state type for the byte-enable simple dual-port RAM.
package sdp_ram_be_clr_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int LAT_1   = 1;
  localparam int LAT_2   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/sdp_ram_core.sv
// Storage array with byte-enable write and a registered read.
// A read and a write to the same address in the same cycle return the old word.
module sdp_ram_core
  import sdp_ram_be_clr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Out-of-range reads return zero rather than aliasing into the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= ({1'b0, raddr} < DEPTH_L) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/sdp_ram_be_clr.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable
// read-during-write result and a zeroing sweep after reset.
module sdp_ram_be_clr
  import sdp_ram_be_clr_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0,
  parameter int CLR_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  if (DATA_W % 8 != 0) begin : g_chk_width
    $error("sdp_ram_be_clr: DATA_W must be a multiple of 8");
  end
  if (RD_LAT != LAT_1 && RD_LAT != LAT_2) begin : g_chk_lat
    $error("sdp_ram_be_clr: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_chk_depth
    $error("sdp_ram_be_clr: DEPTH must be in 1..2**ADDR_W");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLR_EN != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    init_busy   = 1'b0;
    case (state)
      ST_CLEAR: begin
        init_busy   = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt   = ST_READY;
          clr_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  logic ready, usr_wr, rd_acc;
  assign ready  = (state == ST_READY) && !rst;
  assign usr_wr = ready && wr_en;
  assign rd_acc = ready && rd_en;

  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [NB-1:0]     core_be;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  always_comb begin
    core_we    = usr_wr;
    core_waddr = wr_addr;
    core_be    = wr_be;
    core_wdata = wr_data;
    if (init_busy && !rst) begin
      core_we    = 1'b1;
      core_waddr = clr_cnt;
      core_be    = '1;
      core_wdata = '0;
    end
  end

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .we    (core_we),
    .waddr (core_waddr),
    .wbe   (core_be),
    .wdata (core_wdata),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (core_rdata)
  );

  // The core always returns the old word; for new-data mode the colliding
  // write's enabled bytes are captured here and merged over it one cycle later.
  logic              byp_hit, byp, rd_v1;
  logic [NB-1:0]     byp_be;
  logic [DATA_W-1:0] byp_dat, s1_dat;

  assign byp_hit = (RDW_MODE == RDW_NEW) && usr_wr && (wr_addr == rd_addr)
                   && ({1'b0, rd_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1   <= 1'b0;
      byp     <= 1'b0;
      byp_be  <= '0;
      byp_dat <= '0;
    end else begin
      rd_v1 <= rd_acc;
      if (rd_acc) begin
        byp     <= byp_hit;
        byp_be  <= wr_be;
        byp_dat <= wr_data;
      end
    end
  end

  always_comb begin
    s1_dat = core_rdata;
    if (byp) begin
      for (int i = 0; i < NB; i++) begin
        if (byp_be[i]) s1_dat[8*i +: 8] = byp_dat[8*i +: 8];
      end
    end
  end

  if (RD_LAT == LAT_2) begin : g_lat2
    logic [DATA_W-1:0] s2_dat;
    logic              s2_v;
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_dat <= '0;
        s2_v   <= 1'b0;
      end else begin
        s2_v <= rd_v1;
        if (rd_v1) s2_dat <= s1_dat;
      end
    end
    assign rd_data  = s2_dat;
    assign rd_valid = s2_v;
  end else begin : g_lat1
    assign rd_data  = s1_dat;
    assign rd_valid = rd_v1;
  end

endmodule
